add_operand_loader: RTL

Upstream feeder for the 64-bit adder test wrapper. It takes operands over a narrow valid/ready beat bus and assembles them into full-width `a`, `b` and `cin` words. It presents each operand pair with a valid/ready handshake directly to the wrapper's input pipeline register. Beats arrive LSB-first: all of `a`, then all of `b`.

---
 rtl/adder_pkg.sv | 19 +
 rtl/beat_slice_reg.sv | 34 +++
 rtl/add_operand_loader.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the adder operand loader: FSM encoding, default widths
// and the beat-counter width helper.
package adder_pkg;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        PRESENT = 2'd2
    } load_state_e;

    localparam int DEFAULT_DATA_W = 64;
    localparam int DEFAULT_BEAT_W = 16;

    // A single-beat operand still needs a one-bit counter to stay legal.
    function automatic int beat_cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/beat_slice_reg.sv
// DATA_W-wide register written one BEAT_W slice at a time, selected by idx_i.
// Asynchronous active-low reset clears the whole word.
module beat_slice_reg #(
    parameter int DATA_W = 64,
    parameter int BEAT_W = 16,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [BEAT_W-1:0] data_i,
    output logic [DATA_W-1:0] q_o
);

    localparam int BEATS = DATA_W / BEAT_W;

    logic [DATA_W-1:0] q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (we_i) begin
            for (int i = 0; i < BEATS; i++) begin
                if (idx_i == IDX_W'(i)) begin
                    q_q[i*BEAT_W +: BEAT_W] <= data_i;
                end
            end
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/add_operand_loader.sv
// Assembles LSB-first beats into a/b/cin operand words for the adder wrapper.
// Optional framing check on in_last with err pulse: OPERAND_LOADER_LAST_CHK_EN.
module add_operand_loader
    import adder_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int BEAT_W = DEFAULT_BEAT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BEAT_W-1:0] in_data,
    input  logic              in_cin,
`ifdef OPERAND_LOADER_LAST_CHK_EN
    input  logic              in_last,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              cin
`ifdef OPERAND_LOADER_LAST_CHK_EN
    ,
    output logic              err
`endif
);

    localparam int BEATS = DATA_W / BEAT_W;
    localparam int CNT_W = beat_cnt_width(BEATS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    load_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cin_q, cin_d;
    logic             out_valid_q, out_valid_d;
    logic             accept;
    logic             final_b;
    logic             we_a, we_b;
`ifdef OPERAND_LOADER_LAST_CHK_EN
    logic             err_q, err_d;
`endif

    assign in_ready = (state_q != PRESENT);
    assign accept   = in_valid && in_ready;
    assign final_b  = (state_q == LOAD_B) && (cnt_q == LAST_CNT);
    assign we_a     = accept && (state_q == LOAD_A);
    assign we_b     = accept && (state_q == LOAD_B);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cin_d   = cin_q;
`ifdef OPERAND_LOADER_LAST_CHK_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            LOAD_A: begin
                if (accept) begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = LOAD_B;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (accept) begin
                    if (cnt_q == LAST_CNT) begin
                        cin_d   = in_cin;
                        cnt_d   = '0;
                        state_d = PRESENT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    state_d = LOAD_A;
                end
            end
            default: begin
                state_d = LOAD_A;
                cnt_d   = '0;
            end
        endcase
`ifdef OPERAND_LOADER_LAST_CHK_EN
        // An early marker abandons the partial pair; a missing one only flags it.
        if (accept) begin
            if (in_last && !final_b) begin
                err_d   = 1'b1;
                cnt_d   = '0;
                state_d = LOAD_A;
            end else if (!in_last && final_b) begin
                err_d = 1'b1;
            end
        end
`endif
        out_valid_d = (state_d == PRESENT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD_A;
            cnt_q       <= '0;
            cin_q       <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef OPERAND_LOADER_LAST_CHK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cin_q       <= cin_d;
            out_valid_q <= out_valid_d;
`ifdef OPERAND_LOADER_LAST_CHK_EN
            err_q       <= err_d;
`endif
        end
    end

    beat_slice_reg #(
        .DATA_W (DATA_W),
        .BEAT_W (BEAT_W),
        .IDX_W  (CNT_W)
    ) u_a_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (we_a),
        .idx_i  (cnt_q),
        .data_i (in_data),
        .q_o    (a)
    );

    beat_slice_reg #(
        .DATA_W (DATA_W),
        .BEAT_W (BEAT_W),
        .IDX_W  (CNT_W)
    ) u_b_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (we_b),
        .idx_i  (cnt_q),
        .data_i (in_data),
        .q_o    (b)
    );

    assign out_valid = out_valid_q;
    assign cin       = cin_q;
`ifdef OPERAND_LOADER_LAST_CHK_EN
    assign err       = err_q;
`endif

endmodule
